// File: rtl/axi4lite_regfile_if.sv
// axi4lite_regfile_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master and slave views.
interface axi4lite_regfile_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi4lite_regfile.sv
// axi4lite_regfile: AXI4-Lite slave with byte-strobed R/W control registers, read-only status
// registers, per-register write pulses and SLVERR for status/out-of-range accesses.
module axi4lite_regfile #(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_CTRL = 4,
    parameter int NUM_STAT = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    axi4lite_regfile_if.slave                      s_axi,
    output logic [NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_CTRL-1:0]                    ctrl_wr,
    input  logic [NUM_STAT*C_S_AXI_DATA_WIDTH-1:0] stat_in
);
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic awready_q, awready_d, wready_q, wready_d;
    logic aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [IW-1:0] awidx_q, awidx_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d;
    logic [NUM_CTRL-1:0] ctrl_wr_q, ctrl_wr_d;
    logic [DW-1:0] ctrl_q [NUM_CTRL];
    logic [DW-1:0] ctrl_d [NUM_CTRL];
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0] rresp_q, rresp_d;

    logic aw_hs, w_hs, ar_hs, aw_have, w_have;
    logic [IW-1:0] widx, ridx;
    logic [DW-1:0] wdat;
    logic [DW/8-1:0] wstb;
    logic unused_addr_lsbs;

    assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
    assign w_hs = s_axi.S_AXI_WVALID & wready_q;
    assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;
    assign aw_have = aw_got_q | aw_hs;
    assign w_have = w_got_q | w_hs;
    // A beat arriving this cycle takes precedence over the held one (they never coexist).
    assign widx = aw_hs ? s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : awidx_q;
    assign wdat = w_hs ? s_axi.S_AXI_WDATA : wdata_q;
    assign wstb = w_hs ? s_axi.S_AXI_WSTRB : wstrb_q;
    assign ridx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d = wready_q;
        aw_got_d = aw_got_q;
        w_got_d = w_got_q;
        awidx_d = awidx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d = bresp_q;
        ctrl_wr_d = '0;
        ctrl_d = ctrl_q;
        if (w_state_q == W_IDLE) begin
            aw_got_d = aw_have;
            w_got_d = w_have;
            awidx_d = widx;
            wdata_d = wdat;
            wstrb_d = wstb;
            awready_d = !aw_have;
            wready_d = !w_have;
            if (aw_have && w_have) begin
                w_state_d = W_RESP;
                aw_got_d = 1'b0;
                w_got_d = 1'b0;
                awready_d = 1'b0;
                wready_d = 1'b0;
                bvalid_d = 1'b1;
                bresp_d = SLVERR;
                for (int i = 0; i < NUM_CTRL; i++)
                    if (32'(widx) == i) begin
                        bresp_d = OKAY;
                        ctrl_wr_d[i] = 1'b1;
                        for (int b = 0; b < DW/8; b++)
                            if (wstb[b]) ctrl_d[i][8*b +: 8] = wdat[8*b +: 8];
                    end
            end
        end else if (s_axi.S_AXI_BREADY) begin
            w_state_d = W_IDLE;
            bvalid_d = 1'b0;
            awready_d = 1'b1;
            wready_d = 1'b1;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d = rvalid_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (r_state_q == R_IDLE) begin
            arready_d = 1'b1;
            if (ar_hs) begin
                r_state_d = R_RESP;
                arready_d = 1'b0;
                rvalid_d = 1'b1;
                rdata_d = '0;
                rresp_d = SLVERR;
                for (int i = 0; i < NUM_CTRL; i++)
                    if (32'(ridx) == i) begin
                        rdata_d = ctrl_q[i];
                        rresp_d = OKAY;
                    end
                for (int s = 0; s < NUM_STAT; s++)
                    if (32'(ridx) == NUM_CTRL + s) begin
                        rdata_d = stat_in[s*DW +: DW];
                        rresp_d = OKAY;
                    end
            end
        end else if (s_axi.S_AXI_RREADY) begin
            r_state_d = R_IDLE;
            rvalid_d = 1'b0;
            arready_d = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awready_q <= 1'b0;
            wready_q <= 1'b0;
            aw_got_q <= 1'b0;
            w_got_q <= 1'b0;
            awidx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q <= '0;
            ctrl_wr_q <= '0;
            ctrl_q <= '{default: '0};
            arready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awready_q <= awready_d;
            wready_q <= wready_d;
            aw_got_q <= aw_got_d;
            w_got_q <= w_got_d;
            awidx_q <= awidx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            bvalid_q <= bvalid_d;
            bresp_q <= bresp_d;
            ctrl_wr_q <= ctrl_wr_d;
            ctrl_q <= ctrl_d;
            arready_q <= arready_d;
            rvalid_q <= rvalid_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_pack
        assign ctrl_out[g*DW +: DW] = ctrl_q[g];
    end

    assign ctrl_wr = ctrl_wr_q;
    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY = wready_q;
    assign s_axi.S_AXI_BVALID = bvalid_q;
    assign s_axi.S_AXI_BRESP = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID = rvalid_q;
    assign s_axi.S_AXI_RDATA = rdata_q;
    assign s_axi.S_AXI_RRESP = rresp_q;
endmodule

// File: tb/tb_axi4lite_regfile.sv
// tb_axi4lite_regfile: directed self-checking bench; inputs driven and outputs sampled on the falling edge.
module tb_axi4lite_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [127:0] ctrl_out;
    logic [3:0] ctrl_wr;
    logic [127:0] stat_in = '0;
    int checks = 0;
    int failures = 0;
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] rd;

    axi4lite_regfile_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    axi4lite_regfile #(
        .C_S_AXI_ADDR_WIDTH(6),
        .C_S_AXI_DATA_WIDTH(32),
        .NUM_CTRL(4),
        .NUM_STAT(4)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi(bus),
        .ctrl_out(ctrl_out),
        .ctrl_wr(ctrl_wr),
        .stat_in(stat_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r, output logic [3:0] p);
        int n;
        logic a_ok, w_ok;
        n = 0;
        bus.S_AXI_AWADDR = a;
        bus.S_AXI_WDATA = d;
        bus.S_AXI_WSTRB = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && n < 20) begin
            a_ok = bus.S_AXI_AWREADY;
            w_ok = bus.S_AXI_WREADY;
            @(negedge clk);
            if (a_ok) bus.S_AXI_AWVALID = 1'b0;
            if (w_ok) bus.S_AXI_WVALID = 1'b0;
            n++;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID = 1'b0;
        chk("wr_handshake_in_time", 128'(n < 20), 128'(1));
        chk("wr_bvalid_after_hs", 128'(bus.S_AXI_BVALID), 128'(1));
        r = bus.S_AXI_BRESP;
        p = ctrl_wr;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        chk("wr_pulse_single_cycle", 128'(ctrl_wr), 128'(0));
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        logic ok;
        n = 0;
        bus.S_AXI_ARADDR = a;
        bus.S_AXI_ARVALID = 1'b1;
        while (bus.S_AXI_ARVALID && n < 20) begin
            ok = bus.S_AXI_ARREADY;
            @(negedge clk);
            if (ok) bus.S_AXI_ARVALID = 1'b0;
            n++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        chk("rd_handshake_in_time", 128'(n < 20), 128'(1));
        chk("rd_rvalid_after_hs", 128'(bus.S_AXI_RVALID), 128'(1));
        d = bus.S_AXI_RDATA;
        r = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        chk("rd_rvalid_drop", 128'(bus.S_AXI_RVALID), 128'(0));
    endtask

    function automatic logic [4:0] flags();
        return {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY};
    endfunction

    initial begin
        bus.S_AXI_AWADDR = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;
        bus.S_AXI_WSTRB = '0;
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_flags", 128'(flags()), 128'(0));
        chk("reset_ctrl_out", ctrl_out, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_readies", 128'(flags()), 128'(5'b00111));

        axi_write(6'h08, 32'h12345678, 4'hF, resp, pulse);
        chk("pre_reset_pulse", 128'(pulse), 128'(4'b0100));
        chk("pre_reset_reg2", 128'(ctrl_out[95:64]), 128'(32'h12345678));

        // AW captured, W still pending, then reset mid-cycle
        bus.S_AXI_AWADDR = 6'h04;
        bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        chk("aw_held_w_pending", 128'(flags()), 128'(5'b00011));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_flags", 128'(flags()), 128'(0));
        chk("async_reset_ctrl_out", ctrl_out, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerelease_readies", 128'(flags()), 128'(5'b00111));

        // W three cycles ahead of AW; a surviving stale AW would complete the write early
        bus.S_AXI_WDATA = 32'hDEADBEEF;
        bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0;
        repeat (2) begin
            chk("w_first_waiting", 128'(flags()), 128'(5'b00101));
            @(negedge clk);
        end
        bus.S_AXI_AWADDR = 6'h00;
        bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        chk("w_first_bvalid", 128'(flags()), 128'(5'b10001));
        chk("w_first_bresp", 128'(bus.S_AXI_BRESP), 128'(2'b00));
        chk("w_first_pulse", 128'(ctrl_wr), 128'(4'b0001));
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        chk("w_first_done", 128'(flags()), 128'(5'b00111));
        axi_read(6'h00, rd, resp);
        chk("readback_deadbeef", 128'(rd), 128'(32'hDEADBEEF));
        chk("readback_okay", 128'(resp), 128'(2'b00));

        axi_write(6'h04, 32'h11223344, 4'hF, resp, pulse);
        chk("strb_full_resp", 128'(resp), 128'(2'b00));
        chk("strb_full_pulse", 128'(pulse), 128'(4'b0010));
        axi_write(6'h04, 32'hAABBCCDD, 4'h5, resp, pulse);
        chk("strb_5_resp", 128'(resp), 128'(2'b00));
        chk("strb_5_pulse", 128'(pulse), 128'(4'b0010));
        axi_read(6'h05, rd, resp);
        chk("strb_5_data", 128'(rd), 128'(32'h11BB33DD));
        axi_write(6'h0C, 32'hFFFFFFFF, 4'h0, resp, pulse);
        chk("strb_0_pulse", 128'(pulse), 128'(4'b1000));
        chk("strb_0_unchanged", ctrl_out, {32'h0, 32'h0, 32'h11BB33DD, 32'hDEADBEEF});

        stat_in[95:64] = 32'h0000CAFE;
        stat_in[31:0] = 32'h1234ABCD;
        axi_read(6'h18, rd, resp);
        chk("stat2_data", 128'(rd), 128'(32'h0000CAFE));
        chk("stat2_resp", 128'(resp), 128'(2'b00));
        axi_read(6'h10, rd, resp);
        chk("stat0_data", 128'(rd), 128'(32'h1234ABCD));
        axi_write(6'h18, 32'hFFFFFFFF, 4'hF, resp, pulse);
        chk("stat_wr_resp", 128'(resp), 128'(2'b10));
        chk("stat_wr_pulse", 128'(pulse), 128'(0));
        chk("stat_wr_no_change", ctrl_out, {32'h0, 32'h0, 32'h11BB33DD, 32'hDEADBEEF});
        axi_read(6'h3C, rd, resp);
        chk("oor_rd_data", 128'(rd), 128'(0));
        chk("oor_rd_resp", 128'(resp), 128'(2'b10));
        axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, resp, pulse);
        chk("oor_wr_resp", 128'(resp), 128'(2'b10));
        chk("oor_wr_pulse", 128'(pulse), 128'(0));

        // Same-cycle read and write of reg 0, then hold both responses with further beats offered
        bus.S_AXI_ARADDR = 6'h00;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_AWADDR = 6'h00;
        bus.S_AXI_WDATA = 32'hCAFEF00D;
        bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_ARADDR = 6'h04;
        bus.S_AXI_AWADDR = 6'h04;
        bus.S_AXI_WDATA = 32'h0BADBEEF;
        chk("conc_flags", 128'(flags()), 128'(5'b11000));
        chk("conc_pulse", 128'(ctrl_wr), 128'(4'b0001));
        chk("conc_old_data", 128'(bus.S_AXI_RDATA), 128'(32'hDEADBEEF));
        chk("conc_new_reg", ctrl_out, {32'h0, 32'h0, 32'h11BB33DD, 32'hCAFEF00D});
        repeat (5) begin
            @(negedge clk);
            chk("bp_flags", 128'({flags(), ctrl_wr}), 128'({5'b11000, 4'b0000}));
            chk("bp_rdata", 128'({bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_BRESP}),
                128'({32'hDEADBEEF, 2'b00, 2'b00}));
            chk("bp_ctrl_out", ctrl_out, {32'h0, 32'h0, 32'h11BB33DD, 32'hCAFEF00D});
        end
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        chk("bp_release", 128'(flags()), 128'(5'b00111));
        axi_read(6'h00, rd, resp);
        chk("conc_later_read", 128'(rd), 128'(32'hCAFEF00D));
        axi_read(6'h04, rd, resp);
        chk("bp_no_extra_write", 128'(rd), 128'(32'h11BB33DD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi4lite_regfile.md
# axi4lite_regfile

Parametrised AXI4-Lite slave register file: the next generation of the team's two-register AXI4-Lite block. It handles the AXI4-Lite channels directly and provides a configurable number of read/write control registers with byte-strobe writes, a configurable number of read-only status registers, per-register write pulses, and SLVERR responses for illegal accesses. It sits between the PS AXI interconnect and fabric datapaths as their control/status window.

## Interface
Parameters:
- C_S_AXI_ADDR_WIDTH, 6, byte address width; word index = addr[C_S_AXI_ADDR_WIDTH-1:2], addr[1:0] ignored.
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- NUM_CTRL, 4, number of R/W control registers, at word indices 0..NUM_CTRL-1.
- NUM_STAT, 4, number of read-only status registers, at word indices NUM_CTRL..NUM_CTRL+NUM_STAT-1.
- Constraint: NUM_CTRL+NUM_STAT <= 2^(C_S_AXI_ADDR_WIDTH-2), NUM_CTRL >= 1, NUM_STAT >= 0.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWREADY  in, in, out  ADDR_WIDTH, 1, 1  write address channel.
- S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WREADY  in, in, in, out  DATA_WIDTH, 4, 1, 1  write data channel.
- S_AXI_BRESP, S_AXI_BVALID, S_AXI_BREADY  out, out, in  2, 1, 1  write response channel.
- S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARREADY  in, in, out  ADDR_WIDTH, 1, 1  read address channel.
- S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, S_AXI_RREADY  out, out, out, in  DATA_WIDTH, 2, 1, 1  read data channel.
- ctrl_out  out  NUM_CTRL*DATA_WIDTH  control register contents; register i occupies bits [i*32+31:i*32].
- ctrl_wr  out  NUM_CTRL  one-cycle pulse on bit i when control register i is written.
- stat_in  in  NUM_STAT*DATA_WIDTH  status values, same packing as ctrl_out.

## Operation
Reset:
- While ARESETN is low, all registers and outputs are 0, including the AWREADY/WREADY/ARREADY outputs.
- Readies go to 1 at the first rising edge after deassertion.
- Reset asserted mid-transaction immediately discards pending AW/W captures and drops BVALID/RVALID.

Write path (states W_IDLE, W_RESP):
- W_IDLE:
  - AWREADY=1 until an AW beat has been captured; WREADY=1 until a W beat has been captured.
  - AW and W are accepted in either order or in the same cycle; the captured beat is held while the other one is awaited.
- At the edge where the second of the two handshakes completes:
  - Perform the write and set BVALID=1; go to W_RESP.
  - AWREADY=WREADY=0.
- W_RESP: hold BVALID and BRESP until BREADY=1, then return to W_IDLE with both readies at 1 on the next cycle.
- Only one write is outstanding at a time.
- Write effect by target:
  - Control index i: for each lane b with WSTRB[b]=1, reg[i][8b+7:8b] = WDATA[8b+7:8b]. ctrl_wr[i]=1 for exactly the cycle BVALID first rises, even if WSTRB=0. BRESP=OKAY (2'b00).
  - Status index or out of range: no register change, no ctrl_wr pulse, BRESP=SLVERR (2'b10).

Read path (states R_IDLE, R_RESP):
- R_IDLE: ARREADY=1.
- At the AR handshake edge: register RDATA and RRESP, set RVALID=1, set ARREADY=0; go to R_RESP.
- R_RESP: hold RDATA, RRESP and RVALID until RREADY=1, then return to R_IDLE.
- Read data by target:
  - Control index: current register value, RRESP=OKAY.
  - Status index: stat_in slice sampled at the handshake edge, RRESP=OKAY.
  - Out of range: RDATA=0, RRESP=SLVERR.
- Read and write paths are fully independent and may complete in the same cycle. A read of a control register whose write completes at the same edge returns the pre-write value.

## Timing
- Write latency: ctrl_out and BVALID update at the edge of the last AW/W handshake, i.e. visible 1 cycle after that handshake.
- Fastest write: 2 cycles per transaction (handshake cycle plus BVALID cycle with BREADY=1).
- Read latency: RVALID is asserted 1 cycle after the AR handshake.
- Fastest read: 2 cycles per transaction.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Backpressure: BVALID/RVALID stay high for any number of cycles with BREADY/RREADY low; no new AW/W/AR beat is accepted meanwhile.

## Test plan
- Reset:
  - Stimulus: assert ARESETN low mid-write, with AW captured and W pending.
  - Required: BVALID=0 and ctrl_out=0 immediately; readies=1 the first edge after release; a subsequent write to addr 0x0 of 0xDEADBEEF with WSTRB=0xF reads back 0xDEADBEEF.
- Byte strobes:
  - Stimulus: ctrl reg 1 (addr 0x4) = 0x11223344, then write 0xAABBCCDD with WSTRB=0x5.
  - Required: reads 0x11BB33DD; ctrl_wr=0b0010 for exactly one cycle per write.
- Channel ordering:
  - Stimulus: W sent 3 cycles before AW; then AW and W sent in the same cycle.
  - Required: both writes complete with BRESP=OKAY, and BVALID rises the cycle after the later handshake.
- Status and errors (NUM_CTRL=4, NUM_STAT=4):
  - Stimulus: stat_in slice 2 = 0x0000CAFE, read addr 0x18; write addr 0x18; read and write addr 0x3C.
  - Required: read returns 0xCAFE/OKAY; status write returns SLVERR with no state change; addr 0x3C returns RDATA=0/SLVERR and BRESP=SLVERR.
- Backpressure and concurrency:
  - Stimulus: hold RREADY and BREADY low for 5 cycles; then issue a read and a write to the same control register in the same cycle.
  - Required: outputs stable throughout, no extra beats accepted; the read returns the old value and a later read returns the new value.
